// File: rtl/player_draw_pkg.sv
// Shared types and constants for the player sprite redraw engine.
`timescale 1ns/1ps
package player_draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2
  } draw_state_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int CNT_W    = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;

endpackage

// File: rtl/sprite_scan.sv
// Row-major column/row scanner over a SPRITE_W x SPRITE_H box; exposes next-cycle counts
// so the caller can register pixel coordinates in step with the counters.
`timescale 1ns/1ps
module sprite_scan
  import player_draw_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  output logic [CNT_W-1:0] nxt_col,
  output logic [CNT_W-1:0] nxt_row,
  output logic             last
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(SPRITE_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(SPRITE_H - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 4'd1;
      end else begin
        col_d = col_q + 4'd1;
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign nxt_col = col_d;
  assign nxt_row = row_d;
  assign last    = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/player_draw.sv
// Per-frame player sprite redraw: erase the old box, then draw the new one, one pixel per cycle.
// Optional off-screen clipping is enabled with the PLAYER_DRAW_CLIP_EN macro.
`timescale 1ns/1ps
module player_draw
  import player_draw_pkg::*;
#(
  parameter int         SPRITE_W  = 8,
  parameter int         SPRITE_H  = 10,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frameEn,
  input  logic [7:0] posX,
  input  logic [6:0] posY,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColour,
  output logic       plot,
  output logic       busy
);

  draw_state_e state_q, state_d;
  logic       prev_valid_q, prev_valid_d;
  logic [7:0] prev_x_q, prev_x_d, new_x_q, new_x_d, vga_x_q, vga_x_d;
  logic [6:0] prev_y_q, prev_y_d, new_y_q, new_y_d, vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d;

  logic             scan_start, scan_adv, scan_last, pix_on;
  logic [CNT_W-1:0] nxt_col, nxt_row;
  logic [7:0]       base_x;
  logic [6:0]       base_y;
`ifdef PLAYER_DRAW_CLIP_EN
  logic [8:0]       sum_x;
  logic [7:0]       sum_y;
`else
  logic [7:0]       sum_x;
  logic [6:0]       sum_y;
`endif

  sprite_scan #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
    .clock   (clock),
    .reset   (reset),
    .start   (scan_start),
    .advance (scan_adv),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .last    (scan_last)
  );

  // Outputs are computed for the pixel the counters move to, so they line up after the edge.
  always_comb begin
    state_d      = state_q;
    prev_valid_d = prev_valid_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    colour_d     = colour_q;
    scan_start   = 1'b0;
    scan_adv     = 1'b0;
    pix_on       = 1'b0;
    base_x       = new_x_q;
    base_y       = new_y_q;
    case (state_q)
      ST_IDLE: begin
        if (frameEn) begin
          new_x_d    = posX;
          new_y_d    = posY;
          scan_start = 1'b1;
          pix_on     = 1'b1;
          if (prev_valid_q) begin
            state_d  = ST_ERASE;
            base_x   = prev_x_q;
            base_y   = prev_y_q;
            colour_d = BG_COLOUR;
          end else begin
            state_d  = ST_DRAW;
            base_x   = posX;
            base_y   = posY;
            colour_d = FG_COLOUR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        pix_on = 1'b1;
        if (scan_last) begin
          state_d    = ST_DRAW;
          scan_start = 1'b1;
          colour_d   = FG_COLOUR;
        end else begin
          scan_adv = 1'b1;
          base_x   = prev_x_q;
          base_y   = prev_y_q;
          colour_d = BG_COLOUR;
        end
      end
      ST_DRAW: begin
        if (scan_last) begin
          state_d      = ST_IDLE;
          scan_start   = 1'b1;
          prev_x_d     = new_x_q;
          prev_y_d     = new_y_q;
          prev_valid_d = 1'b1;
        end else begin
          scan_adv = 1'b1;
          pix_on   = 1'b1;
          colour_d = FG_COLOUR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PLAYER_DRAW_CLIP_EN
    sum_x = {1'b0, base_x} + {5'd0, nxt_col};
    sum_y = {1'b0, base_y} + {4'd0, nxt_row};
`else
    sum_x = base_x + {4'd0, nxt_col};
    sum_y = base_y + {3'd0, nxt_row};
`endif

    if (pix_on) begin
      vga_x_d = sum_x[7:0];
      vga_y_d = sum_y[6:0];
      busy_d  = 1'b1;
`ifdef PLAYER_DRAW_CLIP_EN
      plot_d  = (sum_x <= 9'(SCREEN_W - 1)) && (sum_y <= 8'(SCREEN_H - 1));
`else
      plot_d  = 1'b1;
`endif
    end else begin
      vga_x_d = vga_x_q;
      vga_y_d = vga_y_q;
      busy_d  = 1'b0;
      plot_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_valid_q <= 1'b0;
      prev_x_q     <= 8'd0;
      prev_y_q     <= 7'd0;
      new_x_q      <= 8'd0;
      new_y_q      <= 7'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      colour_q     <= BG_COLOUR;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
    end
  end

  assign vgaX      = vga_x_q;
  assign vgaY      = vga_y_q;
  assign vgaColour = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;

endmodule

// File: doc/player_draw.md
PLAYER_DRAW -- requirements
Module: player_draw

Interface
REQ-001 SHALL have parameter SPRITE_W, default 8: sprite width in pixels (1..16).
REQ-002 SHALL have parameter SPRITE_H, default 10: sprite height in pixels (1..16).
REQ-003 SHALL have parameter FG_COLOUR, default 3'b100: player pixel colour.
REQ-004 SHALL have parameter BG_COLOUR, default 3'b000: erase colour.
REQ-005 SHALL have port clock, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port frameEn, input, 1: one-cycle pulse per video frame, starts a redraw.
REQ-008 SHALL have port posX, input, 8: player upper-left X, sampled on accepted frameEn.
REQ-009 SHALL have port posY, input, 7: player upper-left Y, sampled on accepted frameEn.
REQ-010 SHALL have port vgaX, output, 8: pixel X to VGA adapter.
REQ-011 SHALL have port vgaY, output, 7: pixel Y to VGA adapter.
REQ-012 SHALL have port vgaColour, output, 3: pixel colour.
REQ-013 SHALL have port plot, output, 1: write-enable for current vgaX/vgaY/vgaColour.
REQ-014 SHALL have port busy, output, 1: high while a redraw is in progress.

Function
REQ-015 SHALL implement states IDLE, ERASE, DRAW.
REQ-016 In IDLE, frameEn=1 SHALL latch posX/posY into newX/newY and go to ERASE if prevValid=1, else DRAW.
REQ-017 frameEn while not IDLE SHALL be ignored; no queuing.
REQ-018 ERASE SHALL scan SPRITE_W x SPRITE_H pixels at prevX/prevY, row-major (column counter inner), one pixel per cycle, vgaColour=BG_COLOUR.
REQ-019 DRAW SHALL scan the same pattern at newX/newY with vgaColour=FG_COLOUR.
REQ-020 After the last ERASE pixel SHALL go to DRAW next cycle with counters cleared; after the last DRAW pixel SHALL copy newX/newY to prevX/prevY, set prevValid=1, return to IDLE.
REQ-021 All outputs SHALL be registered; first pixel appears in the cycle after the edge that accepted frameEn.
REQ-022 Pixel coordinates SHALL be base+offset truncated to 8 bits (X) and 7 bits (Y).
REQ-023 busy SHALL be high exactly for the cycles plot-sequence outputs are valid: 2*W*H cycles with erase, W*H without.
REQ-024 plot SHALL be 0 in IDLE; vgaX/vgaY/vgaColour hold last value in IDLE.
REQ-025 Unchanged position SHALL still erase then redraw.

Reset
REQ-026 reset=1 SHALL force IDLE, counters 0, prevValid=0, prevX/prevY/newX/newY=0, vgaX=0, vgaY=0, vgaColour=BG_COLOUR, plot=0, busy=0, next cycle, including mid-scan.
REQ-027 reset SHALL take priority over frameEn in the same cycle.

Configuration
REQ-028 Macro PLAYER_DRAW_CLIP_EN defined: pixels with untruncated X>159 or Y>119 SHALL have plot=0 while scan timing and busy are unchanged.
REQ-029 Macro PLAYER_DRAW_CLIP_EN undefined: all pixels SHALL be plotted with wrapped coordinates per REQ-022.

Structure
REQ-030 Package player_draw_pkg SHALL hold the state enum, SCREEN_W=160, SCREEN_H=120, and colour constants.
REQ-031 Sub-module sprite_scan SHALL hold the column/row counters, with start/last-pixel signals, reused for ERASE and DRAW.

Verification
REQ-032 Reset, frameEn with pos (20,30): 80 plots FG_COLOUR, X 20..27, Y 30..39 row-major, busy 80 cycles, no erase.
REQ-033 Second frameEn with pos (23,30): 80 BG plots at (20..27,30..39), then 80 FG plots at (23..30,30..39), busy 160 cycles.
REQ-034 frameEn pulsed mid-DRAW: ignored, pixel count and coordinates unchanged.
REQ-035 reset asserted at pixel 40 of ERASE: next cycle plot=0, busy=0; following frameEn draws only, no erase.
REQ-036 Pos (155,115) with PLAYER_DRAW_CLIP_EN: only X 155..159, Y 115..119 plotted (25 plots), busy 80 cycles; without macro 80 plots with wrapped X 155..162 -> 155..162 (8-bit) and Y 115..124 wrapping past 127 not reached.
